// File: rtl/bist_run_supervisor.sv
// rtl/bist_run_supervisor.sv - push-button launch and run-verdict supervisor for the SRAM BIST engine
//
// Ports:
//   Clock, Resetn            system clock, asynchronous active-low reset
//   PB_start_n               raw active-low push-button, asynchronous to Clock
//   BIST_finish              engine idle/done flag
//   BIST_mismatch            engine sticky mismatch flag
//   BIST_address[17:0]       engine's current SRAM address
//   BIST_start               one-cycle launch pulse to the engine
//   run_busy                 high from launch until the verdict is latched
//   run_pass/fail/timeout    verdict of the last run (at most one set)
//   first_fail_address[17:0] BIST_address when the first mismatch was seen
//   run_count, fail_count    saturating counts of runs and failing/hung runs
module bist_run_supervisor #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int TIMEOUT_CYCLES  = 2097152,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 PB_start_n,
  input  logic                 BIST_finish,
  input  logic                 BIST_mismatch,
  input  logic [17:0]          BIST_address,
  output logic                 BIST_start,
  output logic                 run_busy,
  output logic                 run_pass,
  output logic                 run_fail,
  output logic                 run_timeout,
  output logic [17:0]          first_fail_address,
  output logic [CNT_WIDTH-1:0] run_count,
  output logic [CNT_WIDTH-1:0] fail_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    ACK_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_ACK,
    S_RUNNING,
    S_DONE
  } state_e;

  logic                 sync1_q, sync2_q;
  logic                 deb_q, deb_d;
  logic [DW-1:0]        deb_cnt_q, deb_cnt_d;
  logic                 press_q;

  state_e               state_q, state_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 tmo_q, tmo_d;
  logic                 seen_q, seen_d;
  logic [17:0]          ffa_q, ffa_d;
  logic [TW-1:0]        cyc_q, cyc_d;
  logic [2:0]           ack_q, ack_d;
  logic [CNT_WIDTH-1:0] runs_q, runs_d;
  logic [CNT_WIDTH-1:0] fails_q, fails_d;

  // The counter only advances while a level change is pending; any return to
  // the debounced level restarts the stability window from zero.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync1_q   <= PB_start_n;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= deb_q & ~deb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    seen_d  = seen_q;
    ffa_d   = ffa_q;
    cyc_d   = cyc_q;
    ack_d   = ack_q;
    runs_d  = runs_q;
    fails_d = fails_q;

    case (state_q)
      S_IDLE: begin
        if (press_q) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        tmo_d   = 1'b0;
        seen_d  = 1'b0;
        ffa_d   = '0;
        cyc_d   = '0;
        ack_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (!BIST_finish) begin
          state_d = S_RUNNING;
        end else if (ack_q == ACK_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      S_RUNNING: begin
        cyc_d = cyc_q + 1'b1;
        if (BIST_mismatch && !seen_q) begin
          ffa_d  = BIST_address;
          seen_d = 1'b1;
        end
        // Finish is tested first so it wins over a coincident timeout.
        if (BIST_finish) begin
          fail_d  = seen_q | BIST_mismatch;
          pass_d  = ~(seen_q | BIST_mismatch);
          state_d = S_DONE;
        end else if (cyc_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!(&runs_q)) runs_d = runs_q + 1'b1;
        if ((fail_q || tmo_q) && !(&fails_q)) fails_d = fails_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The start pulse trails S_LAUNCH by one cycle so it lands after the
    // verdict registers have been cleared.
    start_d = (state_q == S_LAUNCH);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
      seen_q  <= 1'b0;
      ffa_q   <= '0;
      cyc_q   <= '0;
      ack_q   <= '0;
      runs_q  <= '0;
      fails_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
      seen_q  <= seen_d;
      ffa_q   <= ffa_d;
      cyc_q   <= cyc_d;
      ack_q   <= ack_d;
      runs_q  <= runs_d;
      fails_q <= fails_d;
    end
  end

  assign BIST_start         = start_q;
  assign run_busy           = busy_q;
  assign run_pass           = pass_q;
  assign run_fail           = fail_q;
  assign run_timeout        = tmo_q;
  assign first_fail_address = ffa_q;
  assign run_count          = runs_q;
  assign fail_count         = fails_q;

endmodule

// File: tb/tb_bist_run_supervisor.sv
// tb/tb_bist_run_supervisor.sv - self-checking bench for bist_run_supervisor
module tb_bist_run_supervisor;

  localparam int DEB = 120;
  localparam int TMO = 400;
  // 2 synchronizer + 120 stable + press register + launch cycle
  localparam int START_LATENCY = 124;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b1;
  logic        PB_start_n = 1'b1;
  logic        BIST_finish = 1'b1;
  logic        BIST_mismatch = 1'b0;
  logic [17:0] BIST_address = '0;
  logic        BIST_start, run_busy, run_pass, run_fail, run_timeout;
  logic [17:0] first_fail_address;
  logic [7:0]  run_count, fail_count;

  logic        pb_f = 1'b1;
  logic        fin_f = 1'b1;
  logic        mm_f = 1'b0;
  logic [17:0] addr_f = '0;
  logic        start_f, busy_f, pass_f, fail_f, tmo_f;
  logic [17:0] ffa_f;
  logic [7:0]  runs_f, fails_f;

  int n_checks = 0;
  int n_fail = 0;
  int n_starts = 0;

  bist_run_supervisor #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
    .Clock(Clock), .Resetn(Resetn), .PB_start_n(PB_start_n),
    .BIST_finish(BIST_finish), .BIST_mismatch(BIST_mismatch), .BIST_address(BIST_address),
    .BIST_start(BIST_start), .run_busy(run_busy), .run_pass(run_pass), .run_fail(run_fail),
    .run_timeout(run_timeout), .first_fail_address(first_fail_address),
    .run_count(run_count), .fail_count(fail_count)
  );

  bist_run_supervisor #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut_fast (
    .Clock(Clock), .Resetn(Resetn), .PB_start_n(pb_f),
    .BIST_finish(fin_f), .BIST_mismatch(mm_f), .BIST_address(addr_f),
    .BIST_start(start_f), .run_busy(busy_f), .run_pass(pass_f), .run_fail(fail_f),
    .run_timeout(tmo_f), .first_fail_address(ffa_f),
    .run_count(runs_f), .fail_count(fails_f)
  );

  initial forever #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine stand-in: after each start it drops finish cfg_ack cycles later,
  // raises mismatch cfg_mm cycles after that, and finishes cfg_len cycles
  // after the drop. Negative values mean "never".
  int          cfg_ack = 2;
  int          cfg_len = 20;
  int          cfg_mm = -1;
  logic [17:0] cfg_addr = '0;
  int          eng_t = -1;

  initial forever begin
    @(negedge Clock or negedge Resetn);
    if (!Resetn) begin
      BIST_finish = 1'b1; BIST_mismatch = 1'b0; BIST_address = '0; eng_t = -1;
    end else if (BIST_start === 1'b1) begin
      BIST_finish = 1'b1; BIST_mismatch = 1'b0; eng_t = 0;
    end else if (eng_t >= 0) begin
      eng_t++;
      BIST_address = 18'(eng_t * 5);
      if (cfg_ack >= 0 && eng_t == cfg_ack) BIST_finish = 1'b0;
      if (cfg_ack >= 0 && cfg_mm >= 0 && eng_t == cfg_ack + cfg_mm) begin
        BIST_mismatch = 1'b1;
        BIST_address  = cfg_addr;
      end
      if (cfg_ack >= 0 && cfg_len >= 0 && eng_t == cfg_ack + cfg_len) begin
        BIST_finish = 1'b1;
        eng_t = -1;
      end
    end
  end

  int ef = -1;
  initial forever begin
    @(negedge Clock or negedge Resetn);
    if (!Resetn) begin
      fin_f = 1'b1; ef = -1;
    end else if (start_f === 1'b1) begin
      fin_f = 1'b0; ef = 0;
    end else if (ef >= 0) begin
      ef++;
      if (ef == 3) begin fin_f = 1'b1; ef = -1; end
    end
  end

  // Reference model. The button is accepted once the last DEB synchronized
  // samples all disagree with the accepted level; the run is tracked as a
  // phase plus elapsed cycles within that phase.
  localparam int M_IDLE = 0, M_LAUNCH = 1, M_WAIT = 2, M_RUN = 3, M_DONE = 4;
  bit [DEB+1:0] pb_hist = '1;   // [0] = this edge's sample, [i] = i edges ago
  bit [DEB-1:0] win;
  bit           m_deb = 1'b1, m_press = 1'b0, m_seen = 1'b0;
  int           m_phase = M_IDLE, m_elapsed = 0;
  bit           e_start = 0, e_busy = 0, e_pass = 0, e_fail = 0, e_tmo = 0;
  logic [17:0]  e_ffa = '0;
  int           e_runs = 0, e_fails = 0;

  initial forever begin
    @(posedge Clock or negedge Resetn);
    if (!Resetn) begin
      pb_hist = '1; m_deb = 1'b1; m_press = 1'b0; m_seen = 1'b0;
      m_phase = M_IDLE; m_elapsed = 0;
      e_start = 0; e_busy = 0; e_pass = 0; e_fail = 0; e_tmo = 0;
      e_ffa = '0; e_runs = 0; e_fails = 0;
    end else begin
      e_start = 0;
      case (m_phase)
        M_IDLE: if (m_press) m_phase = M_LAUNCH;
        M_LAUNCH: begin
          e_pass = 0; e_fail = 0; e_tmo = 0; e_ffa = '0; m_seen = 0;
          e_start = 1; m_elapsed = 0; m_phase = M_WAIT;
        end
        M_WAIT: begin
          m_elapsed++;
          if (!BIST_finish) begin
            m_phase = M_RUN; m_elapsed = 0;
          end else if (m_elapsed == 8) begin
            e_tmo = 1; m_phase = M_DONE;
          end
        end
        M_RUN: begin
          m_elapsed++;
          if (BIST_mismatch && !m_seen) begin e_ffa = BIST_address; m_seen = 1; end
          if (BIST_finish) begin
            e_fail = m_seen; e_pass = !m_seen; m_phase = M_DONE;
          end else if (m_elapsed == TMO) begin
            e_tmo = 1; m_phase = M_DONE;
          end
        end
        default: begin
          e_runs = (e_runs < 255) ? e_runs + 1 : 255;
          if (e_fail || e_tmo) e_fails = (e_fails < 255) ? e_fails + 1 : 255;
          m_phase = M_IDLE;
        end
      endcase
      e_busy = (m_phase != M_IDLE);

      pb_hist = {pb_hist[DEB:0], PB_start_n};
      win = pb_hist[DEB+1:2];
      m_press = 1'b0;
      if (m_deb && win == '0) begin
        m_deb = 1'b0; m_press = 1'b1;
      end else if (!m_deb && (&win)) begin
        m_deb = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge Clock);
    if (BIST_start === 1'b1) n_starts++;
    chk("BIST_start", 32'(BIST_start), 32'(e_start));
    chk("run_busy", 32'(run_busy), 32'(e_busy));
    chk("run_pass", 32'(run_pass), 32'(e_pass));
    chk("run_fail", 32'(run_fail), 32'(e_fail));
    chk("run_timeout", 32'(run_timeout), 32'(e_tmo));
    chk("first_fail_address", 32'(first_fail_address), 32'(e_ffa));
    chk("run_count", 32'(run_count), 32'(e_runs));
    chk("fail_count", 32'(fail_count), 32'(e_fails));
  end

  initial begin
    #(600000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic press_and_settle(input string name);
    int lat;
    PB_start_n = 1'b0;
    lat = 0;
    while (BIST_start !== 1'b1 && lat < 1000) begin
      @(negedge Clock);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(START_LATENCY));
    repeat (3 * DEB - lat) @(negedge Clock);
    PB_start_n = 1'b1;
    repeat (3 * DEB) @(negedge Clock);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_start"}, 32'(BIST_start), 0);
    chk({name, "_busy"}, 32'(run_busy), 0);
    chk({name, "_pass"}, 32'(run_pass), 0);
    chk({name, "_fail"}, 32'(run_fail), 0);
    chk({name, "_timeout"}, 32'(run_timeout), 0);
    chk({name, "_ffa"}, 32'(first_fail_address), 0);
    chk({name, "_run_count"}, 32'(run_count), 0);
    chk({name, "_fail_count"}, 32'(fail_count), 0);
  endtask

  initial begin
    int s0;
    int lat;
    #2 Resetn = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (3) @(negedge Clock);
    Resetn = 1'b1;
    repeat (5) @(negedge Clock);

    // clean run
    s0 = n_starts;
    cfg_ack = 2; cfg_len = 20; cfg_mm = -1;
    press_and_settle("clean");
    chk("clean_starts", 32'(n_starts - s0), 1);
    chk("clean_pass", 32'(run_pass), 1);
    chk("clean_run_count", 32'(run_count), 1);
    chk("clean_fail_count", 32'(fail_count), 0);

    // chattering button, then stable low
    s0 = n_starts;
    for (int i = 0; i < 20; i++) begin
      repeat (100) @(negedge Clock);
      PB_start_n = ~PB_start_n;
    end
    repeat (100) @(negedge Clock);
    press_and_settle("chatter");
    chk("chatter_starts", 32'(n_starts - s0), 1);
    chk("chatter_pass", 32'(run_pass), 1);
    chk("chatter_run_count", 32'(run_count), 2);

    // mismatch at 18'h00104
    cfg_ack = 3; cfg_len = 40; cfg_mm = 10; cfg_addr = 18'h00104;
    press_and_settle("mismatch");
    chk("mismatch_fail", 32'(run_fail), 1);
    chk("mismatch_pass", 32'(run_pass), 0);
    chk("mismatch_ffa", 32'(first_fail_address), 32'h00104);
    chk("mismatch_fail_count", 32'(fail_count), 1);
    chk("mismatch_run_count", 32'(run_count), 3);

    // engine hangs in the running state
    cfg_ack = 2; cfg_len = -1; cfg_mm = -1;
    press_and_settle("hang");
    chk("hang_timeout", 32'(run_timeout), 1);
    chk("hang_busy", 32'(run_busy), 0);
    chk("hang_run_count", 32'(run_count), 4);
    chk("hang_fail_count", 32'(fail_count), 2);

    // engine never leaves idle
    cfg_ack = -1;
    press_and_settle("noack");
    chk("noack_timeout", 32'(run_timeout), 1);
    chk("noack_fail", 32'(run_fail), 0);
    chk("noack_run_count", 32'(run_count), 5);
    chk("noack_fail_count", 32'(fail_count), 3);

    // second press during a long run is dropped
    cfg_ack = 2; cfg_len = 350; cfg_mm = -1;
    s0 = n_starts;
    PB_start_n = 1'b0;
    lat = 0;
    while (BIST_start !== 1'b1 && lat < 1000) begin @(negedge Clock); lat++; end
    repeat (10) @(negedge Clock);
    PB_start_n = 1'b1;
    repeat (130) @(negedge Clock);
    PB_start_n = 1'b0;
    repeat (130) @(negedge Clock);
    chk("second_press_busy", 32'(run_busy), 1);
    PB_start_n = 1'b1;
    repeat (400) @(negedge Clock);
    chk("second_press_starts", 32'(n_starts - s0), 1);
    chk("second_press_pass", 32'(run_pass), 1);
    chk("second_press_run_count", 32'(run_count), 6);

    // reset mid-run
    s0 = n_starts;
    PB_start_n = 1'b0;
    lat = 0;
    while (BIST_start !== 1'b1 && lat < 1000) begin @(negedge Clock); lat++; end
    repeat (10) @(negedge Clock);
    PB_start_n = 1'b1;
    repeat (50) @(negedge Clock);
    chk("midrun_busy", 32'(run_busy), 1);
    #2 Resetn = 1'b0;
    #1 chk_outputs_zero("midrun_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("reset_hold_start", 32'(BIST_start), 0);
    end
    Resetn = 1'b1;
    repeat (3 * DEB) @(negedge Clock);
    chk("after_reset_starts", 32'(n_starts - s0), 1);
    chk("after_reset_run_count", 32'(run_count), 0);
    chk("after_reset_busy", 32'(run_busy), 0);

    // saturation on the fast-debounce instance
    for (int i = 1; i <= 260; i++) begin
      pb_f = 1'b0;
      repeat (12) @(negedge Clock);
      pb_f = 1'b1;
      repeat (20) @(negedge Clock);
      chk("sat_run_count", 32'(runs_f), (i > 255) ? 255 : i);
      chk("sat_pass", 32'(pass_f), 1);
    end
    chk("sat_fail_count", 32'(fails_f), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
